tm1637_frame_feeder: RTL
========================

TM1637_FRAME_FEEDER -- requirements
Module: tm1637_frame_feeder

Interface
REQ-001 Parameter LEADING_BLANK, default 0; 1 = digit 0 shown blank when its code is 0.
REQ-002 clk  input  1  system clock; single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 update  input  1  one-cycle strobe requesting a full 4-digit refresh.
REQ-005 digits  input  16  four 4-bit codes; [3:0]=digit 0 (leftmost) ... [15:12]=digit 3.
REQ-006 colon  input  1  colon enable; sampled with digits.
REQ-007 ready_data  input  1  level from downstream TM1637 control core; high = next byte may be offered.
REQ-008 data_valid  output  1  one-cycle strobe qualifying data.
REQ-009 data  output  8  byte to control core.
REQ-010 busy  output  1  high while a frame is in progress.
REQ-011 frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted.

Function
REQ-012 On update while IDLE, digits and colon SHALL be latched on that edge; busy rises the next cycle.
REQ-013 A frame SHALL be 8 bytes in order: address 0xC0+i, then segment byte of digit i, for i = 0..3.
REQ-014 Segment encoding: 0..9 -> 3F,06,5B,4F,66,6D,7D,07,7F,6F; codes 10..15 -> 00 (blank).
REQ-015 Bit 7 of the digit-1 segment byte SHALL equal latched colon; bit 7 of other digits SHALL be 0.
REQ-016 With LEADING_BLANK=1 and digit 0 code 0, digit-0 segment byte SHALL be 00.
REQ-017 FSM states: IDLE, WAIT_RDY, SEND, WAIT_ACK.
REQ-018 IDLE -> WAIT_RDY on update; WAIT_RDY -> SEND when ready_data=1.
REQ-019 SEND SHALL assert data_valid for exactly one cycle with data stable, then go to WAIT_ACK.
REQ-020 WAIT_ACK SHALL hold until ready_data=0 is sampled, then advance the byte index (0..7) and go to WAIT_RDY; no second data_valid may be issued while ready_data is still high from the previous offer.
REQ-021 After byte index 7 completes WAIT_ACK: frame_done pulses one cycle, FSM returns to IDLE, busy falls the same cycle.
REQ-022 data SHALL be 00 whenever data_valid=0.
REQ-023 update while busy SHALL set a pending flag and capture digits/colon into a shadow register (latest wins); the active frame SHALL NOT be modified.
REQ-024 On frame completion with pending set: pending clears, shadow loads, FSM goes directly to WAIT_RDY (busy stays high); frame_done still pulses.
REQ-025 update coincident with frame completion SHALL be treated as pending (REQ-024).
REQ-026 Byte index SHALL be 3 bits; digit index = index[2:1], address/segment select = index[0].

Reset
REQ-027 On reset: FSM=IDLE, index=0, pending=0, latched and shadow values=0, data_valid=0, data=00, busy=0, frame_done=0, on the next clk edge.
REQ-028 Reset mid-frame SHALL abort without emitting further bytes; no frame_done.

Structure
REQ-029 Shared package tm1637_pkg SHALL hold: segment table constants, address base 0xC0, colon bit position, FSM state encoding.
REQ-030 One combinational sub-module seg7_encoder (4-bit code + blank -> 7-bit segments); all sequential logic stays in tm1637_frame_feeder.

Verification
REQ-031 digits=16'h4321, colon=1, update; ready_data model high, low one cycle after each data_valid -> bytes C0,06,C1,DB,C2,4F,C3,66; one frame_done.
REQ-032 ready_data held high permanently after first byte -> exactly one data_valid, FSM stuck in WAIT_ACK, busy=1.
REQ-033 LEADING_BLANK=1, digits=16'h5900 colon=0 -> segment bytes 00,3F,6F,6D; digits=16'hFA00 -> 00,3F,00,00.
REQ-034 Second update (digits=16'h9999) during byte 3 of first frame -> first frame unchanged, then second frame immediately, busy never drops, two frame_done pulses.
REQ-035 Reset asserted after byte 4 -> data_valid stays 0, busy=0 next cycle; new update yields full frame from C0.
REQ-036 ready_data delayed 50 cycles per byte -> identical byte sequence, data_valid only while ready_data=1.

Source files
------------

// File: rtl/tm1637_pkg.sv
// Shared constants for the TM1637 frame feeder: segment table, address base,
// colon bit position and FSM state encoding.
package tm1637_pkg;

    localparam logic [7:0]  ADDR_BASE = 8'hC0;
    localparam int unsigned COLON_BIT = 7;

    // Codes 10..15 map to an all-off pattern so the table can be indexed directly.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
    };

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_RDY = 2'd1;
    localparam logic [1:0] ST_SEND     = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK = 2'd3;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational 4-bit code to 7-segment pattern, with a forced-blank override.
module seg7_encoder
    import tm1637_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_TABLE[i_code];
        if (i_blank) begin
            o_seg = '0;
        end
    end

endmodule

// File: rtl/tm1637_frame_feeder.sv
// Streams an 8-byte TM1637 display frame (address/segment pairs for 4 digits)
// to a byte-wide control core using a valid/ready-level handshake.
module tm1637_frame_feeder
    import tm1637_pkg::*;
#(
    parameter bit LEADING_BLANK = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        update,
    input  logic [15:0] digits,
    input  logic        colon,
    input  logic        ready_data,
    output logic        data_valid,
    output logic [7:0]  data,
    output logic        busy,
    output logic        frame_done
);

    logic [1:0]  r_state;
    logic [2:0]  r_index;
    logic [15:0] r_digits;
    logic        r_colon;
    logic        r_pend;
    logic [15:0] r_sh_digits;
    logic        r_sh_colon;
    logic        r_data_valid;
    logic [7:0]  r_data;
    logic        r_busy;
    logic        r_frame_done;

    logic [1:0]  w_digit;
    logic [3:0]  w_code;
    logic        w_blank;
    logic [6:0]  w_seg;
    logic [7:0]  w_seg_byte;
    logic [7:0]  w_byte;

    assign w_digit = r_index[2:1];
    assign w_code  = r_digits[{w_digit, 2'b00} +: 4];
    assign w_blank = LEADING_BLANK && (w_digit == 2'd0) && (w_code == 4'd0);

    seg7_encoder u_enc (
        .i_code  (w_code),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    always_comb begin
        w_seg_byte            = {1'b0, w_seg};
        w_seg_byte[COLON_BIT] = (w_digit == 2'd1) && r_colon;
        w_byte                = r_index[0] ? w_seg_byte : (ADDR_BASE | {6'd0, w_digit});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_digits     <= '0;
            r_colon      <= 1'b0;
            r_pend       <= 1'b0;
            r_sh_digits  <= '0;
            r_sh_colon   <= 1'b0;
            r_data_valid <= 1'b0;
            r_data       <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_data       <= '0;
            r_frame_done <= 1'b0;

            // Requests during a frame go to the shadow; latest one wins.
            if (update && (r_state != ST_IDLE)) begin
                r_pend      <= 1'b1;
                r_sh_digits <= digits;
                r_sh_colon  <= colon;
            end

            case (r_state)
                ST_IDLE: begin
                    if (update) begin
                        r_digits <= digits;
                        r_colon  <= colon;
                        r_index  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (ready_data) begin
                        r_data_valid <= 1'b1;
                        r_data       <= w_byte;
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (!ready_data) begin
                        r_index <= r_index + 3'd1;
                        if (r_index == 3'd7) begin
                            r_frame_done <= 1'b1;
                            // A request arriving on the completion edge is newer than the shadow.
                            if (update) begin
                                r_pend   <= 1'b0;
                                r_digits <= digits;
                                r_colon  <= colon;
                                r_state  <= ST_WAIT_RDY;
                            end else if (r_pend) begin
                                r_pend   <= 1'b0;
                                r_digits <= r_sh_digits;
                                r_colon  <= r_sh_colon;
                                r_state  <= ST_WAIT_RDY;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_state <= ST_WAIT_RDY;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data_valid = r_data_valid;
    assign data       = r_data;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
